// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and default bus widths for the memory arbiter path
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int MEM_ADDR_W = 64;
    localparam int MEM_DATA_W = 64;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first requester after last with wrap
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] winner,
    output logic                 any
);

    localparam int LW = $clog2(N);

    // scan from farthest to nearest so the nearest requester after last is kept
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                winner = LW'((int'(last) + k) % N);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin merge of client requests onto one memory port, one transaction in flight, with watchdog
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CLIENTS    = 2,
    parameter int ADDR_W         = MEM_ADDR_W,
    parameter int DATA_W         = MEM_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        cli_req,
    input  logic [NUM_CLIENTS-1:0]        cli_we,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata,
    output logic [NUM_CLIENTS-1:0]        cli_gnt,
    output logic [NUM_CLIENTS-1:0]        cli_resp_valid,
    output logic                          cli_resp_err,
    output logic [DATA_W-1:0]             cli_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_valid,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int IW = $clog2(NUM_CLIENTS);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                   state_q;
    logic [IW-1:0]            owner_q;
    logic [IW-1:0]            last_q;
    logic [CW-1:0]            tmo_q;
    logic [NUM_CLIENTS-1:0]   gnt_q;
    logic [NUM_CLIENTS-1:0]   resp_valid_q;
    logic                     resp_err_q;
    logic [DATA_W-1:0]        rdata_q;
    logic                     mem_req_q;
    logic                     mem_we_q;
    logic [ADDR_W-1:0]        mem_addr_q;
    logic [DATA_W-1:0]        mem_wdata_q;
    logic [IW-1:0]            win;
    logic                     any;

    rr_pick #(.N(NUM_CLIENTS)) u_pick (
        .req    (cli_req),
        .last   (last_q),
        .winner (win),
        .any    (any)
    );

    // transaction FSM: grant in IDLE, then wait for completion or watchdog expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_q       <= IW'(NUM_CLIENTS - 1);
            tmo_q        <= '0;
            gnt_q        <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            mem_req_q    <= 1'b0;
            gnt_q        <= '0;
            resp_valid_q <= '0;
            if (state_q == IDLE) begin
                if (any) begin
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= cli_we[win];
                    mem_addr_q  <= cli_addr[int'(win)*ADDR_W +: ADDR_W];
                    mem_wdata_q <= cli_wdata[int'(win)*DATA_W +: DATA_W];
                    gnt_q       <= NUM_CLIENTS'(1) << win;
                    owner_q     <= win;
                    last_q      <= win;
                    state_q     <= WAIT;
                end
            end else if (mem_valid) begin
                resp_valid_q <= NUM_CLIENTS'(1) << owner_q;
                resp_err_q   <= 1'b0;
                rdata_q      <= mem_rdata;
                tmo_q        <= '0;
                state_q      <= IDLE;
            end else if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) begin
                resp_valid_q <= NUM_CLIENTS'(1) << owner_q;
                resp_err_q   <= 1'b1;
                rdata_q      <= '0;
                tmo_q        <= '0;
                state_q      <= IDLE;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign cli_gnt        = gnt_q;
    assign cli_resp_valid = resp_valid_q;
    assign cli_resp_err   = resp_err_q;
    assign cli_rdata      = rdata_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed and randomized checks of mem_req_arbiter against a transaction-level model
module tb_mem_req_arbiter;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int T  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    cli_req = '0;
    logic [N-1:0]    cli_we = '0;
    logic [N*AW-1:0] cli_addr = '0;
    logic [N*DW-1:0] cli_wdata = '0;
    logic [N-1:0]    cli_gnt;
    logic [N-1:0]    cli_resp_valid;
    logic            cli_resp_err;
    logic [DW-1:0]   cli_rdata;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_valid = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;

    int n_pass = 0;
    int n_tot  = 0;

    mem_req_arbiter #(
        .NUM_CLIENTS    (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cli_req        (cli_req),
        .cli_we         (cli_we),
        .cli_addr       (cli_addr),
        .cli_wdata      (cli_wdata),
        .cli_gnt        (cli_gnt),
        .cli_resp_valid (cli_resp_valid),
        .cli_resp_err   (cli_resp_err),
        .cli_rdata      (cli_rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_valid      (mem_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // transaction-level reference: busy flag, owner, and an absolute deadline edge
    logic          busy = 1'b0;
    int            owner = 0;
    int            last = N - 1;
    longint        cyc = 0;
    longint        issued = 0;
    logic          e_req = 1'b0;
    logic [N-1:0]  e_gnt = '0;
    logic [N-1:0]  e_rv = '0;
    logic          e_err = 1'b0;
    logic [DW-1:0] e_rdata = '0;
    logic          e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            busy = 1'b0; owner = 0; last = N - 1; cyc = 0; issued = 0;
            e_req = 1'b0; e_gnt = '0; e_rv = '0; e_err = 1'b0; e_rdata = '0;
            e_we = 1'b0; e_addr = '0; e_wdata = '0;
        end else begin
            cyc++;
            e_req = 1'b0; e_gnt = '0; e_rv = '0;
            if (!busy) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (last + k) % N;
                    if (!busy && cli_req[c]) begin
                        busy = 1'b1; owner = c; last = c; issued = cyc;
                        e_req = 1'b1; e_gnt[c] = 1'b1;
                        e_we = cli_we[c]; e_addr = cli_addr[c*AW +: AW]; e_wdata = cli_wdata[c*DW +: DW];
                    end
                end
            end else if (mem_valid) begin
                busy = 1'b0; e_rv[owner] = 1'b1; e_err = 1'b0; e_rdata = mem_rdata;
            end else if (cyc - issued == T) begin
                busy = 1'b0; e_rv[owner] = 1'b1; e_err = 1'b1; e_rdata = '0;
            end
        end
    end

    // compare DUT against the model on every falling edge
    initial forever begin
        @(negedge clk);
        chk("m_mem_req", 64'(mem_req), 64'(e_req));
        chk("m_gnt", 64'(cli_gnt), 64'(e_gnt));
        chk("m_resp_valid", 64'(cli_resp_valid), 64'(e_rv));
        chk("m_mem_bus", {mem_addr[61:0], mem_we, 1'b0} ^ mem_wdata, {e_addr[61:0], e_we, 1'b0} ^ e_wdata);
        if (e_rv != '0) begin
            chk("m_err", 64'(cli_resp_err), 64'(e_err));
            chk("m_rdata", cli_rdata, e_rdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gcnt[N];
        int order[$];
        int k;
        // reset
        tick(); tick();
        chk("rst_outputs", {cli_gnt, cli_resp_valid, mem_req, mem_we} | mem_addr | mem_wdata | cli_rdata, 64'h0);
        #3 rst_n = 1'b1;
        tick();
        // single read from client 0
        cli_req = 2'b01; cli_we = 2'b00; cli_addr[0 +: AW] = 64'h100;
        tick();
        chk("rd_mem_req", 64'(mem_req), 64'h1);
        chk("rd_mem_we", 64'(mem_we), 64'h0);
        chk("rd_mem_addr", mem_addr, 64'h100);
        chk("rd_gnt", 64'(cli_gnt), 64'h1);
        cli_req = '0;
        tick();
        mem_valid = 1'b1; mem_rdata = 64'hDEADBEEF;
        tick();
        mem_valid = 1'b0;
        chk("rd_resp_valid", 64'(cli_resp_valid), 64'h1);
        chk("rd_rdata", cli_rdata, 64'hDEADBEEF);
        chk("rd_err", 64'(cli_resp_err), 64'h0);
        // write from client 1
        cli_req = 2'b10; cli_we = 2'b10; cli_addr[AW +: AW] = 64'h40; cli_wdata[DW +: DW] = 64'h1234;
        tick();
        chk("wr_mem_we", 64'(mem_we), 64'h1);
        chk("wr_mem_addr", mem_addr, 64'h40);
        chk("wr_mem_wdata", mem_wdata, 64'h1234);
        chk("wr_gnt", 64'(cli_gnt), 64'h2);
        cli_req = '0;
        tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("wr_resp_valid", 64'(cli_resp_valid), 64'h2);
        chk("wr_err", 64'(cli_resp_err), 64'h0);
        // fairness with both clients requesting continuously
        cli_req = 2'b11; cli_we = 2'b00;
        gcnt[0] = 0; gcnt[1] = 0;
        for (int i = 0; i < 100 && order.size() < 12; i++) begin
            tick();
            mem_valid = mem_req;
            if (cli_gnt == 2'b01) begin order.push_back(0); gcnt[0]++; end
            if (cli_gnt == 2'b10) begin order.push_back(1); gcnt[1]++; end
        end
        cli_req = '0;
        chk("fair_total", 64'(order.size()), 64'd12);
        for (int i = 0; i < order.size(); i++) chk("fair_order", 64'(order[i]), 64'(i % 2));
        chk("fair_cnt0", 64'(gcnt[0]), 64'd6);
        chk("fair_cnt1", 64'(gcnt[1]), 64'd6);
        for (int i = 0; i < 4; i++) begin tick(); mem_valid = mem_req; end
        mem_valid = 1'b0;
        // timeout with silent memory
        mem_rdata = 64'hFFFF;
        cli_req = 2'b01;
        tick();
        chk("to_gnt", 64'(cli_gnt), 64'h1);
        cli_req = '0;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            tick();
            if (cli_resp_valid != '0) k = i;
        end
        chk("to_latency", 64'(k), 64'(T));
        chk("to_resp_valid", 64'(cli_resp_valid), 64'h1);
        chk("to_err", 64'(cli_resp_err), 64'h1);
        chk("to_rdata", cli_rdata, 64'h0);
        tick(); tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("late_valid_ignored", 64'(cli_resp_valid), 64'h0);
        tick();
        chk("late_valid_ignored2", 64'(cli_resp_valid), 64'h0);
        cli_req = 2'b10;
        tick();
        chk("after_to_gnt", 64'(cli_gnt), 64'h2);
        cli_req = '0;
        tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        // completion arriving on the last allowed wait cycle wins over the timeout
        cli_req = 2'b01;
        tick();
        cli_req = '0;
        for (int i = 0; i < T - 1; i++) tick();
        mem_valid = 1'b1; mem_rdata = 64'hABCD;
        tick();
        mem_valid = 1'b0;
        chk("edge_resp_valid", 64'(cli_resp_valid), 64'h1);
        chk("edge_err", 64'(cli_resp_err), 64'h0);
        chk("edge_rdata", cli_rdata, 64'hABCD);
        // spurious completion while idle
        mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); chk("spur_idle", 64'(cli_resp_valid), 64'h0); end
        mem_valid = 1'b0;
        cli_req = 2'b10;
        tick();
        chk("spur_then_gnt", 64'(cli_gnt), 64'h2);
        cli_req = '0;
        // reset while waiting
        cli_addr[0 +: AW] = 64'h777;
        cli_req = 2'b01;
        tick();
        cli_req = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {cli_gnt, cli_resp_valid, mem_req, mem_we} | mem_addr | mem_wdata | cli_rdata, 64'h0);
        mem_valid = 1'b1;
        tick(); chk("rst_valid_ignored", 64'(cli_resp_valid), 64'h0);
        tick(); chk("rst_valid_ignored2", 64'(cli_resp_valid), 64'h0);
        #2 rst_n = 1'b1;
        tick(); chk("post_rst_valid_ignored", 64'(cli_resp_valid), 64'h0);
        mem_valid = 1'b0;
        cli_req = 2'b11;
        tick();
        chk("post_rst_gnt", 64'(cli_gnt), 64'h1);
        cli_req = '0;
        tick();
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        // randomized traffic with random completions, spurious valids and timeouts
        for (int i = 0; i < 3000; i++) begin
            tick();
            for (int c = 0; c < N; c++) begin
                if (cli_gnt[c]) cli_req[c] = 1'b0;
                if (!cli_req[c] && $urandom_range(0, 2) == 0) begin
                    cli_req[c] = 1'b1;
                    cli_we[c] = 1'($urandom);
                    cli_addr[c*AW +: AW] = {$urandom, $urandom};
                    cli_wdata[c*DW +: DW] = {$urandom, $urandom};
                end
            end
            mem_valid = ($urandom_range(0, 4) == 0);
            mem_rdata = {$urandom, $urandom};
        end
        cli_req = '0;
        mem_valid = 1'b0;
        for (int i = 0; i < T + 4; i++) tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
